// File: rtl/sysbus_arbiter.sv
// Two-master round-robin bus arbiter with slave split and watchdog revocation; grant 1 cycle after request.
// No data path: masters hold req until granted, grants drop the cycle req falls, split or watchdog fires.
module sysbus_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_req,
  input  logic m2_req,
  input  logic split,
  input  logic split_done,
  output logic m1_grant,
  output logic m2_grant,
  output logic msel,
  output logic bus_busy,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  state_t        state;
  logic          last_gnt;   // 0 = master 1, 1 = master 2
  logic [1:0]    split_mask;
  logic [1:0]    to_mask;
  logic [CW-1:0] cnt;

  logic [1:0] req;
  logic [1:0] elig;
  logic       cur_idx;
  logic       cur_req;

  assign req     = {m2_req, m1_req};
  assign elig    = req & ~split_mask & ~to_mask;
  assign cur_idx = (state == GNT2);
  assign cur_req = req[cur_idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      msel        <= 1'b0;
      split_mask  <= 2'b00;
      to_mask     <= 2'b00;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      // A master must be seen idle before a watchdog block is lifted.
      to_mask <= to_mask & req;
      if (split_done) split_mask <= 2'b00;

      case (state)
        IDLE: begin
          if (elig[0] && (!elig[1] || last_gnt)) begin
            state    <= GNT1;
            last_gnt <= 1'b0;
            msel     <= 1'b0;
            cnt      <= '0;
          end else if (elig[1]) begin
            state    <= GNT2;
            last_gnt <= 1'b1;
            msel     <= 1'b1;
            cnt      <= '0;
          end
        end
        GNT1, GNT2: begin
          if (!cur_req) begin
            state <= IDLE;
          end else if (split) begin
            // Overrides a same-cycle split_done clear for this master.
            state               <= IDLE;
            split_mask[cur_idx] <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state            <= IDLE;
            to_mask[cur_idx] <= 1'b1;
            timeout_err      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m1_grant = (state == GNT1);
  assign m2_grant = (state == GNT2);
  assign bus_busy = m1_grant | m2_grant;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Randomized and directed bench for sysbus_arbiter against a cycle-level ownership model.
module tb_sysbus_arbiter;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m1_req = 1'b0, m2_req = 1'b0, split = 1'b0, split_done = 1'b0;
  logic m1_grant, m2_grant, msel, bus_busy, timeout_err;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: owner number, cycles the grant has been visible, last owner.
  int       own, held, last;
  bit [2:1] smask, tmask;
  bit       msel_m, to_m;

  sysbus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .m1_req(m1_req), .m2_req(m2_req),
    .split(split), .split_done(split_done), .m1_grant(m1_grant),
    .m2_grant(m2_grant), .msel(msel), .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = 0; held = 0; last = 2;
    smask = '0; tmask = '0; msel_m = 1'b0; to_m = 1'b0;
  endtask

  task automatic model_edge(input bit r1, input bit r2, input bit sp, input bit sd);
    bit [2:1] rq, el, nsm, ntm;
    int nown;
    bit nto;
    rq   = {r2, r1};
    el   = rq & ~smask & ~tmask;
    nown = own;
    nto  = 1'b0;
    nsm  = sd ? 2'b00 : smask;
    ntm  = tmask & rq;
    if (own == 0) begin
      if (el == 2'b11) nown = (last == 1) ? 2 : 1;
      else if (el[1]) nown = 1;
      else if (el[2]) nown = 2;
      if (nown != 0) begin
        last = nown; msel_m = (nown == 2); held = 1;
      end
    end else if (!rq[own]) begin
      nown = 0;
    end else if (sp) begin
      nown = 0; nsm[own] = 1'b1;
    end else if (held == TIMEOUT) begin
      nown = 0; ntm[own] = 1'b1; nto = 1'b1;
    end else begin
      held++;
    end
    own = nown; smask = nsm; tmask = ntm; to_m = nto;
  endtask

  task automatic check_outs();
    logic [4:0] a, e;
    a = {m1_grant, m2_grant, msel, bus_busy, timeout_err};
    e = {own == 1, own == 2, msel_m, own != 0, to_m};
    check("outs", {27'd0, a}, {27'd0, e});
  endtask

  task automatic step(input bit r1, input bit r2, input bit sp, input bit sd);
    @(negedge clk);
    m1_req = r1; m2_req = r2; split = sp; split_done = sd;
    @(posedge clk);
    model_edge(r1, r2, sp, sd);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    m1_req = 1'b0; m2_req = 1'b0; split = 1'b0; split_done = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_grant(input bit r1, input bit r2, input int who);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(r1, r2, 1'b0, 1'b0);
      ok = (who == 1) ? m1_grant : m2_grant;
    end
    check("wait_grant", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int g, t, c1, c2, gap;
    bit r1, r2, prev_busy;
    int order[$];
    int gaps[$];

    model_reset();
    #1;
    check("reset_outs", {27'd0, m1_grant, m2_grant, msel, bus_busy, timeout_err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single requester for five cycles.
    g = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      g += int'(m1_grant);
      check("single_msel", {31'd0, msel}, 32'd0);
    end
    step(0, 0, 0, 0);
    check("single_drop", {31'd0, m1_grant}, 32'd0);
    check("single_len", g, 5);

    // Both requesting from reset, each drops after three grant cycles.
    do_reset();
    r1 = 1; r2 = 1; c1 = 0; c2 = 0; gap = 0; prev_busy = 0;
    for (int i = 0; i < 60 && order.size() < 4; i++) begin
      step(r1, r2, 0, 0);
      c1 = m1_grant ? c1 + 1 : 0;
      c2 = m2_grant ? c2 + 1 : 0;
      if (bus_busy && !prev_busy) begin
        order.push_back(m1_grant ? 1 : 2);
        gaps.push_back(gap);
        gap = 0;
      end
      if (!bus_busy) gap++;
      prev_busy = bus_busy;
      r1 = !(m1_grant && c1 == 3);
      r2 = !(m2_grant && c2 == 3);
    end
    check("rr_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) check("rr_order", order[k], (k % 2 == 0) ? 1 : 2);
    for (int k = 1; k < gaps.size(); k++) check("rr_gap", gaps[k], 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Split of master 2 while master 1 also waits.
    wait_grant(0, 1, 2);
    step(1, 1, 1, 0);
    check("split_drop", {31'd0, m2_grant}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      check("split_hold", {31'd0, m2_grant}, 32'd0);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("split_masked", {31'd0, m2_grant}, 32'd0);
    step(0, 1, 0, 1);
    check("split_done_edge", {31'd0, m2_grant}, 32'd0);
    step(0, 1, 0, 0);
    check("split_resume", {31'd0, m2_grant}, 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Watchdog on master 1.
    g = 0; t = 0;
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 0);
      g += int'(m1_grant);
      t += int'(timeout_err);
    end
    check("to_len", g, TIMEOUT);
    check("to_pulses", t, 1);
    check("to_blocked", {31'd0, m1_grant}, 32'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("to_regrant", {31'd0, m1_grant}, 32'd1);
    step(0, 0, 0, 0);

    // Split together with release: no mask.
    wait_grant(0, 1, 2);
    step(0, 0, 1, 0);
    check("splrel_drop", {31'd0, m2_grant}, 32'd0);
    step(0, 1, 0, 0);
    check("splrel_regrant", {31'd0, m2_grant}, 32'd1);
    step(0, 0, 0, 0);

    // Split together with watchdog expiry: split wins.
    wait_grant(1, 0, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("splto_err", {31'd0, timeout_err}, 32'd0);
    check("splto_drop", {31'd0, m1_grant}, 32'd0);
    step(1, 0, 0, 0);
    check("splto_masked", {31'd0, m1_grant}, 32'd0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    check("splto_resume", {31'd0, m1_grant}, 32'd1);
    step(0, 0, 0, 0);

    // Asynchronous reset during a master 2 grant.
    wait_grant(0, 1, 2);
    check("pre_rst_msel", {31'd0, msel}, 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    m1_req = 1'b1; m2_req = 1'b1;
    model_reset();
    #1;
    check("rst_m2_grant", {31'd0, m2_grant}, 32'd0);
    check("rst_msel", {31'd0, msel}, 32'd0);
    check_outs();
    @(negedge clk);
    rstn = 1'b1;
    step(1, 1, 0, 0);
    check("rst_tie", {31'd0, m1_grant}, 32'd1);
    step(0, 0, 0, 0);

    // Random traffic.
    r1 = 0; r2 = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        r1 = 0; r2 = 0;
      end
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      if ($urandom_range(0, 5) == 0) r2 = ~r2;
      step(r1, r2, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
